// File: rtl/p2_grms_qsys_pio_in_edge.sv
// p2_grms_qsys_pio_in_edge: Avalon-MM input PIO with synchroniser, edge capture, irq mask and irq
module p2_grms_qsys_pio_in_edge #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);
    localparam logic [31:0] KEEP = 32'((64'd1 << DATA_WIDTH) - 64'd1);
    localparam logic [2:0]  ARM  = 3'(SYNC_STAGES + 1);
    logic [SYNC_STAGES*DATA_WIDTH-1:0] chain;
    logic [DATA_WIDTH-1:0] data_in, prev, edge_det;
    logic [31:0] irq_mask, edge_capture, rd_mux, clr;
    logic [2:0] arm_cnt;
    logic wr, armed;
    always_comb begin
        data_in  = chain[SYNC_STAGES*DATA_WIDTH-1 -: DATA_WIDTH];
        edge_det = EDGE_TYPE == 0 ? data_in & ~prev :
                   EDGE_TYPE == 1 ? ~data_in & prev : data_in ^ prev;
        wr       = chipselect & ~write_n;
        armed    = arm_cnt == ARM;
        clr      = (wr && address == 2'd3) ? writedata : '0;
        rd_mux   = address == 2'd0 ? 32'(data_in) :
                   address == 2'd2 ? irq_mask :
                   address == 2'd3 ? edge_capture : '0;
        irq      = |((IRQ_MODE == 1 ? edge_capture : 32'(data_in)) & irq_mask);
    end
    // upper bits of irq_mask/edge_capture are never set, so they read as 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain        <= '0;
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            arm_cnt      <= '0;
            readdata     <= '0;
        end else begin
            chain        <= {chain[(SYNC_STAGES-1)*DATA_WIDTH-1:0], in_port};
            prev         <= data_in;
            arm_cnt      <= armed ? arm_cnt : arm_cnt + 3'd1;
            if (wr && address == 2'd2) irq_mask <= writedata & KEEP;
            edge_capture <= (edge_capture & ~clr) | (armed ? 32'(edge_det) : '0);
            readdata     <= rd_mux;
        end
    end
endmodule

// File: doc/p2_grms_qsys_pio_in_edge.md
Name: p2_grms_qsys_pio_in_edge

Overview:
Parametrised Avalon-MM input PIO slave, the next generation of the fixed 8-bit input port. Adds a selectable-depth input synchroniser, per-bit edge capture with write-1-to-clear, an interrupt mask and a single irq output (level or edge mode). It sits on the Qsys system interconnect and reads board inputs such as switches, keys and status lines.

Parameters:
DATA_WIDTH, 8, number of input bits, 1..32; readdata bits above DATA_WIDTH read 0.
SYNC_STAGES, 2, synchroniser flop depth on in_port, 2..3.
EDGE_TYPE, 0, edge detected: 0 = rising, 1 = falling, 2 = any.
IRQ_MODE, 1, 0 = level (irq from synchronised data), 1 = edge (irq from edge capture).

Ports:
clk  input  1  system clock; all flops on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
address  input  2  register select.
chipselect  input  1  slave select; qualifies writes only.
write_n  input  1  active-low write strobe.
writedata  input  32  write data; bits [DATA_WIDTH-1:0] used.
in_port  input  DATA_WIDTH  asynchronous external inputs.
readdata  output  32  registered read data.
irq  output  1  active-high interrupt request.

Behaviour:
- Reset (reset_n=0, asynchronous): synchroniser flops, the previous-sample register, edge_capture, irq_mask, the arm counter and readdata all go to 0. irq is 0.
- Synchroniser: in_port passes through a chain of SYNC_STAGES flops. data_in is the last stage. prev is data_in delayed by one clock.
- Edge detect is combinational per bit:
  - rising: data_in & ~prev
  - falling: ~data_in & prev
  - any: data_in ^ prev
- Arm counter: after reset release, edge detection is suppressed for SYNC_STAGES+1 clocks. This blocks a spurious edge while the chain fills. The counter saturates, and once saturated detection stays enabled until the next reset.
- Register map (word addresses):
  - 0: data, read-only, returns data_in. Writes are ignored.
  - 1: reserved. Reads return 0; writes are ignored.
  - 2: irq_mask, read/write, DATA_WIDTH bits.
  - 3: edge_capture, read / write-1-to-clear.
- A write occurs when chipselect=1 and write_n=0, and completes in that cycle with no wait states.
- edge_capture update: each bit is set when its edge is detected and detection is armed. It is cleared by a write to address 3 where the matching writedata bit is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- Read: readdata is updated every clock from the current address (mux output zero-extended to 32 bits), regardless of chipselect. Read latency is 1 clock, so readdata shows the register value sampled at the edge where the address is presented.
- Reading any register has no side effect.
- Latency from input to visibility: an in_port change sampled at edge k:
  - data_in changes after edge k+SYNC_STAGES-1.
  - The edge_capture bit sets after edge k+SYNC_STAGES.
  - Address 0 readdata reflects the change after edge k+SYNC_STAGES.
- irq is combinational from registered state:
  - IRQ_MODE=0: irq = |(data_in & irq_mask)
  - IRQ_MODE=1: irq = |(edge_capture & irq_mask)
- Masking: writing 0 to an irq_mask bit drops irq at once but leaves edge_capture untouched. Unmasking a bit that is already captured raises irq immediately.
- A glitch on in_port shorter than one clock may be missed. Nothing guarantees it is captured.
- Reset asserted mid-operation clears all state asynchronously, including pending captures. The arm window restarts when reset is released.

Test Plan:
All scenarios use DATA_WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, IRQ_MODE=1 unless stated.
1. Reset release with in_port=0xFF held high -> edge_capture reads 0x00 after 10 clocks; data (address 0) reads 0x000000FF; irq=0 even with irq_mask=0xFF.
2. irq_mask=0x01; in_port 0x00->0x01 sampled at edge k -> edge_capture=0x01 and irq=1 after edge k+2; read address 3 returns 0x00000001.
3. Write 0x01 to address 3 -> edge_capture=0x00 and irq=0 the next cycle. Then issue a clear write to bit 0 in the same cycle as a new rising edge on bit 0 -> bit stays 1.
4. irq_mask=0x00 with edge_capture=0x04 -> irq=0; write irq_mask=0x04 -> irq=1 the next cycle; write 0xFB to address 3 -> bit 2 not cleared, still 0x04.
5. EDGE_TYPE=2, IRQ_MODE=0: in_port toggles 0x80 -> 0x00 -> edge_capture=0x80; with irq_mask=0x80, irq follows data_in bit 7 (1 then 0).
6. Reset asserted with edge_capture=0x3C and irq=1 -> all registers read 0 and irq=0 immediately. Writes to address 0 or 1 never change any read value; address 1 always reads 0x00000000.
